// File: rtl/pxi_rd_ctrl.sv
//------------------------------------------------------------------------------
// Module      : pxi_rd_ctrl
// Description : Read-cycle sequencer for the 16-bit PXI read-data buffer pair.
//               Fetches a word from the register file or sample FIFO, presents
//               it on dout and drives the buffer's active-low output enable
//               through setup / drive / turnaround windows.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pxi_rd_ctrl #(
    parameter int              ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] FIFO_ADDR = 8'hF0,
    parameter int              SETUP_CYC = 2,
    parameter int              HOLD_CYC  = 4,
    parameter int              TURN_CYC  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_act,
    output logic [ADDR_W-1:0] reg_addr,
    input  logic [15:0]       reg_rdata,
    output logic              fifo_rd_en,
    input  logic [15:0]       fifo_dout,
    input  logic              fifo_empty,
    output logic [15:0]       dout,
    output logic              den,
    output logic              rd_ack,
    output logic              rd_err,
    output logic              busy
);

    localparam int C_MAXC  = (SETUP_CYC > HOLD_CYC) ?
                             ((SETUP_CYC > TURN_CYC) ? SETUP_CYC : TURN_CYC) :
                             ((HOLD_CYC  > TURN_CYC) ? HOLD_CYC  : TURN_CYC);
    localparam int C_CNT_W = (C_MAXC > 1) ? $clog2(C_MAXC) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_CAPTURE = 3'd2,
        S_SETUP   = 3'd3,
        S_DRIVE   = 3'd4,
        S_TURN    = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]    reg_addr_q, reg_addr_d;
    logic                 fifo_sel_q, fifo_sel_d;   // request targeted the FIFO
    logic                 fifo_ok_q, fifo_ok_d;     // FIFO had data at accept
    logic                 fifo_rd_en_q, fifo_rd_en_d;
    logic [15:0]          dout_q, dout_d;
    logic                 den_q, den_d;
    logic                 rd_ack_q, rd_ack_d;
    logic                 rd_err_q, rd_err_d;
    logic                 busy_q, busy_d;

    // State and output registers; reset parks the buffer in high-impedance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            reg_addr_q   <= '0;
            fifo_sel_q   <= 1'b0;
            fifo_ok_q    <= 1'b0;
            fifo_rd_en_q <= 1'b0;
            dout_q       <= 16'h0000;
            den_q        <= 1'b1;
            rd_ack_q     <= 1'b0;
            rd_err_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            reg_addr_q   <= reg_addr_d;
            fifo_sel_q   <= fifo_sel_d;
            fifo_ok_q    <= fifo_ok_d;
            fifo_rd_en_q <= fifo_rd_en_d;
            dout_q       <= dout_d;
            den_q        <= den_d;
            rd_ack_q     <= rd_ack_d;
            rd_err_q     <= rd_err_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state and next-output logic; outputs are computed for the cycle
    // being entered so that every output except den is a plain register.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        reg_addr_d   = reg_addr_q;
        fifo_sel_d   = fifo_sel_q;
        fifo_ok_d    = fifo_ok_q;
        fifo_rd_en_d = 1'b0;
        dout_d       = dout_q;
        den_d        = 1'b1;
        rd_ack_d     = 1'b0;
        // A request arriving while a cycle is in flight is dropped and flagged.
        rd_err_d     = rd_req && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (rd_req) begin
                    state_d      = S_FETCH;
                    reg_addr_d   = rd_addr;
                    fifo_sel_d   = (rd_addr == FIFO_ADDR);
                    fifo_ok_d    = (rd_addr == FIFO_ADDR) && !fifo_empty;
                    fifo_rd_en_d = (rd_addr == FIFO_ADDR) && !fifo_empty;
                end
            end
            S_FETCH: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d = S_SETUP;
                cnt_d   = C_CNT_W'(SETUP_CYC - 1);
                if (fifo_sel_q) begin
                    dout_d = fifo_ok_q ? fifo_dout : 16'h0000;
                    if (!fifo_ok_q) begin
                        rd_err_d = 1'b1;
                    end
                end else begin
                    dout_d = reg_rdata;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d  = S_DRIVE;
                    cnt_d    = C_CNT_W'(HOLD_CYC - 1);
                    den_d    = 1'b0;
                    rd_ack_d = (HOLD_CYC == 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DRIVE: begin
                if (wr_act) begin
                    // Bus write collided with our drive window: abort.
                    state_d  = S_TURN;
                    cnt_d    = C_CNT_W'(TURN_CYC - 1);
                    rd_err_d = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = S_TURN;
                    cnt_d   = C_CNT_W'(TURN_CYC - 1);
                end else begin
                    cnt_d    = cnt_q - 1'b1;
                    den_d    = 1'b0;
                    rd_ack_d = (cnt_q == C_CNT_W'(1));
                end
            end
            S_TURN: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign reg_addr   = reg_addr_q;
    assign fifo_rd_en = fifo_rd_en_q;
    assign dout       = dout_q;
    // Only combinational output: a bus write forces the buffer off at once.
    assign den        = den_q | wr_act;
    assign rd_ack     = rd_ack_q;
    assign rd_err     = rd_err_q;
    assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_pxi_rd_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_pxi_rd_ctrl
// Description : Directed self-checking bench for pxi_rd_ctrl.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pxi_rd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req;
    logic [7:0]  rd_addr;
    logic        wr_act;
    logic [7:0]  reg_addr;
    logic [15:0] reg_rdata;
    logic        fifo_rd_en;
    logic [15:0] fifo_dout;
    logic        fifo_empty;
    logic [15:0] dout;
    logic        den;
    logic        rd_ack;
    logic        rd_err;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] fifo_val;

    pxi_rd_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .wr_act     (wr_act),
        .reg_addr   (reg_addr),
        .reg_rdata  (reg_rdata),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .dout       (dout),
        .den        (den),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Register-file model: one-cycle latency, known word at 8'h12.
    always @(posedge clk) begin
        reg_rdata <= (reg_addr == 8'h12) ? 16'hA55A : {8'h5C, reg_addr};
    end

    // FIFO model: data only valid the cycle after a pop, garbage otherwise.
    always @(posedge clk) begin
        fifo_dout <= fifo_rd_en ? fifo_val : 16'hBAD0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full read starting in the current cycle (cycle 0). abort_cyc < 0 means
    // no write collision; err_cyc < 0 means no data-path error pulse.
    // Returns aligned to the first IDLE cycle.
    task automatic do_read(input logic [7:0] addr, input logic empty,
                           input logic [15:0] exp_dout, input int err_cyc,
                           input int abort_cyc);
        int last;
        last = (abort_cyc >= 0) ? abort_cyc + 3 : 11;
        rd_req     = 1'b1;
        rd_addr    = addr;
        fifo_empty = empty;
        for (int c = 1; c <= last; c++) begin
            tick();
            rd_req = 1'b0;
            wr_act = (c == abort_cyc);
            #1;
            chk($sformatf("den_c%0d", c), 32'(den),
                32'(!((c >= 5) && (c <= 8) && ((abort_cyc < 0) || (c < abort_cyc)))));
            chk($sformatf("ack_c%0d", c), 32'(rd_ack), 32'((abort_cyc < 0) && (c == 8)));
            chk($sformatf("busy_c%0d", c), 32'(busy), 32'(c < last));
            chk($sformatf("err_c%0d", c), 32'(rd_err),
                32'((c == err_cyc) || ((abort_cyc >= 0) && (c == abort_cyc + 1))));
            chk($sformatf("fren_c%0d", c), 32'(fifo_rd_en),
                32'((c == 1) && (addr == 8'hF0) && !empty));
            if (c >= 3) begin
                chk($sformatf("dout_c%0d", c), 32'(dout), 32'(exp_dout));
            end
        end
        wr_act = 1'b0;
    endtask

    initial begin
        int acks;
        rst        = 1'b1;
        rd_req     = 1'b0;
        rd_addr    = 8'h00;
        wr_act     = 1'b0;
        fifo_empty = 1'b0;
        fifo_val   = 16'h1234;
        tick();
        tick();
        chk("rst_den", 32'(den), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_ack", 32'(rd_ack), 32'd0);
        chk("rst_err", 32'(rd_err), 32'd0);
        chk("rst_fren", 32'(fifo_rd_en), 32'd0);
        chk("rst_addr", 32'(reg_addr), 32'd0);
        rst = 1'b0;
        tick();

        // Register read.
        do_read(8'h12, 1'b0, 16'hA55A, -1, -1);
        chk("reg_addr_latched", 32'(reg_addr), 32'h12);

        // FIFO read with data.
        do_read(8'hF0, 1'b0, 16'h1234, -1, -1);

        // FIFO read while empty: zero driven, error after capture.
        do_read(8'hF0, 1'b1, 16'h0000, 3, -1);
        fifo_empty = 1'b0;

        // Write collision in cycle 6 of a register read.
        do_read(8'h34, 1'b0, 16'h5C34, -1, 6);

        // Overrun: second request in cycle 4 dropped, accepted again in 11.
        rd_req  = 1'b1;
        rd_addr = 8'h12;
        acks    = 0;
        for (int c = 1; c <= 11; c++) begin
            tick();
            rd_req  = (c == 4);
            rd_addr = (c == 4) ? 8'h77 : 8'h12;
            #1;
            if (rd_ack) acks++;
            if (c >= 3 && c <= 10) begin
                chk($sformatf("ovr_busy_c%0d", c), 32'(busy), 32'd1);
            end
            chk($sformatf("ovr_err_c%0d", c), 32'(rd_err), 32'(c == 5));
        end
        rd_req = 1'b0;
        chk("ovr_acks", 32'(acks), 32'd1);
        chk("ovr_dout", 32'(dout), 32'hA55A);
        chk("ovr_addr", 32'(reg_addr), 32'h12);
        do_read(8'h12, 1'b0, 16'hA55A, -1, -1);

        // Asynchronous reset during the drive window.
        rd_req  = 1'b1;
        rd_addr = 8'h12;
        for (int c = 1; c <= 6; c++) begin
            tick();
            rd_req = 1'b0;
        end
        chk("pre_rst_den", 32'(den), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_den", 32'(den), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_dout", 32'(dout), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        do_read(8'h12, 1'b0, 16'hA55A, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/pxi_rd_ctrl.md
# pxi_rd_ctrl

Read-cycle sequencer for the 16-bit PXI read-data buffer pair. It accepts a read request from the PXI local-bus decoder and fetches the word from either the register file or the sample FIFO. It presents the word on the buffer inputs and drives the buffer's active-low output enable with programmed setup, drive and turnaround windows. It never lets the buffer drive while a bus write is active.

## Interface
- ADDR_W, 8, read address width
- FIFO_ADDR, 8'hF0, address that maps to the sample FIFO; all other addresses go to the register file
- SETUP_CYC, 2, cycles data is stable before `den` falls (≥1)
- HOLD_CYC, 4, cycles `den` is held low (≥1)
- TURN_CYC, 2, bus-turnaround cycles with `den` high before the next accept (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rd_req  in  1  single-cycle read request pulse, synchronous to clk
- rd_addr  in  ADDR_W  read address, valid with rd_req
- wr_act  in  1  PXI write cycle in progress; buffer must not drive
- reg_addr  out  ADDR_W  register-file read address (registered)
- reg_rdata  in  16  register-file read data, 1-cycle latency
- fifo_rd_en  out  1  FIFO pop strobe, 1 cycle wide
- fifo_dout  in  16  FIFO read data, 1-cycle latency after fifo_rd_en
- fifo_empty  in  1  FIFO empty flag
- dout  out  16  data to buffer inputs
- den  out  1  buffer output enable, active low
- rd_ack  out  1  read-complete pulse
- rd_err  out  1  error pulse (overrun, empty FIFO, write abort)
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE → FETCH → CAPTURE → SETUP → DRIVE → TURN → IDLE.
- IDLE with rd_req=1:
  - latch rd_addr into reg_addr and go to FETCH.
  - If rd_addr==FIFO_ADDR and fifo_empty=0, set fifo_rd_en=1 for the FETCH cycle only.
- FETCH: one cycle; the source produces data.
- CAPTURE: one cycle. At its end, dout is loaded with:
  - fifo_dout if FIFO address and not empty;
  - 16'h0000 if FIFO address and empty, with an rd_err pulse;
  - otherwise reg_rdata.
- SETUP: SETUP_CYC cycles, den=1, dout stable.
- DRIVE: HOLD_CYC cycles, den=0. rd_ack=1 in the last DRIVE cycle only.
- TURN: TURN_CYC cycles, den=1, then IDLE.
- An empty FIFO still runs the full sequence; 0 is driven and rd_ack is issued.
- Overrun: rd_req while busy=1 is dropped, with an rd_err pulse the next cycle. No state change.
- Write protection: den = den_q | wr_act (the only combinational path). wr_act=1 during DRIVE:
  - den goes high in the same cycle;
  - the next state is TURN with no rd_ack and an rd_err pulse.
- wr_act during SETUP delays nothing; only DRIVE aborts.
- dout holds its value after a cycle until the next CAPTURE.
- Phase counter is sized for max(SETUP_CYC, HOLD_CYC, TURN_CYC) and reloads on every state entry.

## Timing
- Reset values: reg_addr=0, fifo_rd_en=0, dout=0, den=1, rd_ack=0, rd_err=0, busy=0, state=IDLE. Reset mid-cycle forces den high asynchronously.
- rd_req in cycle 0 gives:
  - FETCH in cycle 1;
  - CAPTURE in cycle 2;
  - SETUP in cycles 3..2+S;
  - DRIVE in cycles 3+S..2+S+H;
  - TURN for the next T cycles;
  - IDLE in cycle 3+S+H+T.
- Defaults (S=2, H=4, T=2): den low in cycles 5–8, rd_ack in cycle 8, busy in cycles 1–10, next rd_req accepted in cycle 11.
- rd_err is registered and is a 1-cycle pulse. Simultaneous error sources produce a single pulse.
- All outputs except den are registered.

## Test plan
- Register read, rd_addr=8'h12, reg_rdata=16'hA55A, defaults → dout=16'hA55A from cycle 3, den low cycles 5–8, rd_ack cycle 8, busy low cycle 11.
- FIFO read, rd_addr=8'hF0, fifo_empty=0, fifo_dout=16'h1234 → fifo_rd_en high exactly in cycle 1, dout=16'h1234, den low cycles 5–8, rd_ack cycle 8.
- FIFO read with fifo_empty=1 → fifo_rd_en never high, dout=16'h0000, rd_err pulse, den low cycles 5–8, rd_ack cycle 8.
- wr_act high in cycle 6 of a default read → den high in cycle 6, TURN cycles 7–8, IDLE cycle 9, no rd_ack, rd_err one pulse.
- rd_req in cycles 0 and 4 → second request ignored with rd_err in cycle 5, one rd_ack only; rd_req in cycle 11 is accepted.
- rst asserted in cycle 6 (den low) → den=1, busy=0, dout=0 immediately; after release, a fresh read completes with default timing.
